// File: rtl/oem_sort_pipe.sv
// oem_sort_pipe: 3-stage 4-key odd-even merge sorter with valid/ready stall.
// Define OEM_SORT_IDX_EN to carry and output per-key source lane indices.
module oem_sort_pipe #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_desc,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
`ifdef OEM_SORT_IDX_EN
  output logic [1:0]       out_idx0,
  output logic [1:0]       out_idx1,
  output logic [1:0]       out_idx2,
  output logic [1:0]       out_idx3,
`endif
  output logic             busy
);

  typedef logic [3:0][WIDTH-1:0] keys_t;

  logic  v1_q, v2_q, v3_q;
  logic  d1_q, d2_q, d3_q;
  keys_t k1_q, k2_q, k3_q;
  keys_t k1_d, k2_d, k3_d;
  keys_t kin;
  logic  adv;
  logic  sa, sb, sc, sd, se;

`ifdef OEM_SORT_IDX_EN
  typedef logic [3:0][1:0] idxs_t;
  idxs_t i1_q, i2_q, i3_q;
  idxs_t i1_d, i2_d, i3_d;

  // Index breaks key ties so equal keys leave in lane order.
  function automatic logic swp(input logic d,
                               input logic [WIDTH-1:0] x,
                               input logic [WIDTH-1:0] y,
                               input logic [1:0] ix,
                               input logic [1:0] iy);
    logic tie;
    tie = (x == y) && (ix > iy);
    return d ? ((x < y) || tie) : ((x > y) || tie);
  endfunction
`else
  function automatic logic swp(input logic d,
                               input logic [WIDTH-1:0] x,
                               input logic [WIDTH-1:0] y);
    return d ? (x < y) : (x > y);
  endfunction
`endif

  always_comb begin
    adv = !v3_q || out_ready;
    kin = {in3, in2, in1, in0};
`ifdef OEM_SORT_IDX_EN
    sa = swp(in_desc, in0, in1, 2'd0, 2'd1);
    sb = swp(in_desc, in2, in3, 2'd2, 2'd3);
    sc = swp(d1_q, k1_q[0], k1_q[2], i1_q[0], i1_q[2]);
    sd = swp(d1_q, k1_q[1], k1_q[3], i1_q[1], i1_q[3]);
    se = swp(d2_q, k2_q[1], k2_q[2], i2_q[1], i2_q[2]);
`else
    sa = swp(in_desc, in0, in1);
    sb = swp(in_desc, in2, in3);
    sc = swp(d1_q, k1_q[0], k1_q[2]);
    sd = swp(d1_q, k1_q[1], k1_q[3]);
    se = swp(d2_q, k2_q[1], k2_q[2]);
`endif
    k1_d[0] = sa ? kin[1] : kin[0];
    k1_d[1] = sa ? kin[0] : kin[1];
    k1_d[2] = sb ? kin[3] : kin[2];
    k1_d[3] = sb ? kin[2] : kin[3];
    k2_d[0] = sc ? k1_q[2] : k1_q[0];
    k2_d[2] = sc ? k1_q[0] : k1_q[2];
    k2_d[1] = sd ? k1_q[3] : k1_q[1];
    k2_d[3] = sd ? k1_q[1] : k1_q[3];
    k3_d[0] = k2_q[0];
    k3_d[1] = se ? k2_q[2] : k2_q[1];
    k3_d[2] = se ? k2_q[1] : k2_q[2];
    k3_d[3] = k2_q[3];
  end

`ifdef OEM_SORT_IDX_EN
  always_comb begin
    i1_d[0] = sa ? 2'd1 : 2'd0;
    i1_d[1] = sa ? 2'd0 : 2'd1;
    i1_d[2] = sb ? 2'd3 : 2'd2;
    i1_d[3] = sb ? 2'd2 : 2'd3;
    i2_d[0] = sc ? i1_q[2] : i1_q[0];
    i2_d[2] = sc ? i1_q[0] : i1_q[2];
    i2_d[1] = sd ? i1_q[3] : i1_q[1];
    i2_d[3] = sd ? i1_q[1] : i1_q[3];
    i3_d[0] = i2_q[0];
    i3_d[1] = se ? i2_q[2] : i2_q[1];
    i3_d[2] = se ? i2_q[1] : i2_q[2];
    i3_d[3] = i2_q[3];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q <= '0;
      i2_q <= '0;
      i3_q <= '0;
    end else if (adv) begin
      if (in_valid) i1_q <= i1_d;
      i2_q <= i2_d;
      i3_q <= i3_d;
    end
  end

  assign out_idx0 = i3_q[0];
  assign out_idx1 = i3_q[1];
  assign out_idx2 = i3_q[2];
  assign out_idx3 = i3_q[3];
`endif

  // Whole pipe moves or freezes together; bubbles are kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      d1_q <= 1'b0;
      d2_q <= 1'b0;
      d3_q <= 1'b0;
      k1_q <= '0;
      k2_q <= '0;
      k3_q <= '0;
    end else if (adv) begin
      v1_q <= in_valid;
      if (in_valid) begin
        d1_q <= in_desc;
        k1_q <= k1_d;
      end
      v2_q <= v1_q;
      d2_q <= d1_q;
      k2_q <= k2_d;
      v3_q <= v2_q;
      d3_q <= d2_q;
      k3_q <= k3_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign out0      = k3_q[0];
  assign out1      = k3_q[1];
  assign out2      = k3_q[2];
  assign out3      = k3_q[3];
  assign busy      = v1_q | v2_q | v3_q;

  logic unused_d3;
  assign unused_d3 = d3_q;

endmodule

// File: tb/tb_oem_sort_pipe.sv
// tb_oem_sort_pipe: randomized and directed checks of oem_sort_pipe
// against a selection-sort reference model.
module tb_oem_sort_pipe;
  localparam int W = 6;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_desc;
  logic out_valid, out_ready, busy;
  logic [W-1:0] in0, in1, in2, in3;
  logic [W-1:0] out0, out1, out2, out3;
`ifdef OEM_SORT_IDX_EN
  logic [1:0] out_idx0, out_idx1, out_idx2, out_idx3;
`endif

  int checks = 0;
  int failures = 0;

  typedef logic [3:0][W-1:0] keys_t;
  typedef logic [3:0][1:0]   idxs_t;
  typedef struct packed {
    keys_t k;
    idxs_t ix;
  } beat_t;

  always #5 clk = ~clk;

  oem_sort_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_desc   (in_desc),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
`ifdef OEM_SORT_IDX_EN
    .out_idx0  (out_idx0),
    .out_idx1  (out_idx1),
    .out_idx2  (out_idx2),
    .out_idx3  (out_idx3),
`endif
    .busy      (busy)
  );

  // Pick the best remaining lane for each output slot; lower lane wins ties.
  function automatic beat_t model(input keys_t k, input logic desc);
    beat_t b;
    logic [3:0] used;
    int best;
    b = '0;
    used = '0;
    for (int p = 0; p < 4; p++) begin
      best = -1;
      for (int l = 0; l < 4; l++) begin
        if (!used[l]) begin
          if (best < 0) best = l;
          else if (desc ? (k[l] > k[best]) : (k[l] < k[best])) best = l;
        end
      end
      used[best] = 1'b1;
      b.k[p] = k[best];
      b.ix[p] = best[1:0];
    end
    return b;
  endfunction

  function automatic keys_t got_k();
    return {out3, out2, out1, out0};
  endfunction

`ifdef OEM_SORT_IDX_EN
  function automatic idxs_t got_i();
    return {out_idx3, out_idx2, out_idx1, out_idx0};
  endfunction
`endif

  function automatic keys_t rand_keys();
    keys_t k;
    for (int i = 0; i < 4; i++)
      k[i] = ($urandom % 2 == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
    return k;
  endfunction

  task automatic drive(input keys_t k, input logic d, input logic v);
    in0 = k[0];
    in1 = k[1];
    in2 = k[2];
    in3 = k[3];
    in_desc = d;
    in_valid = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive('0, 1'b0, 1'b0);
    out_ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    drive('0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (got_k() !== keys_t'(0)) begin
      failures++;
      $display("FAIL reset_keys got=%h exp=0", got_k());
    end
  endtask

  task automatic test_directed();
    keys_t vk [4];
    logic  vd [4];
    keys_t ek [4];
    vk[0] = {6'd17, 6'd63, 6'd3, 6'd45}; vd[0] = 1'b0;
    ek[0] = {6'd63, 6'd45, 6'd17, 6'd3};
    vk[1] = {6'd17, 6'd63, 6'd3, 6'd45}; vd[1] = 1'b1;
    ek[1] = {6'd3, 6'd17, 6'd45, 6'd63};
    vk[2] = {6'd9, 6'd0, 6'd9, 6'd9};    vd[2] = 1'b0;
    ek[2] = {6'd9, 6'd9, 6'd9, 6'd0};
    vk[3] = {6'd63, 6'd63, 6'd63, 6'd63}; vd[3] = 1'b0;
    ek[3] = {6'd63, 6'd63, 6'd63, 6'd63};
`ifdef OEM_SORT_IDX_EN
    begin
      idxs_t ei [4];
      ei[0] = {2'd2, 2'd0, 2'd3, 2'd1};
      ei[1] = {2'd1, 2'd3, 2'd0, 2'd2};
      ei[2] = {2'd3, 2'd1, 2'd0, 2'd2};
      ei[3] = {2'd3, 2'd2, 2'd1, 2'd0};
`endif
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(vk[c], vd[c], 1'b1);
      for (int s = 1; s <= 3; s++) begin
        step();
        drive('0, 1'b0, 1'b0);
        if (s < 3) begin
          checks++;
          if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL dir%0d_early_valid s=%0d got=%b exp=0", c, s, out_valid);
          end
        end else begin
          checks++;
          if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL dir%0d_latency got=%b exp=1", c, out_valid);
          end
          checks++;
          if (got_k() !== ek[c]) begin
            failures++;
            $display("FAIL dir%0d_keys got=%h exp=%h", c, got_k(), ek[c]);
          end
`ifdef OEM_SORT_IDX_EN
          checks++;
          if (got_i() !== ei[c]) begin
            failures++;
            $display("FAIL dir%0d_idx got=%h exp=%h", c, got_i(), ei[c]);
          end
`endif
        end
      end
    end
`ifdef OEM_SORT_IDX_EN
    end
`endif
  endtask

  task automatic test_stream();
    beat_t exp [8];
    keys_t k;
    int nvalid = 0;
    out_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c >= 3) begin
        checks++;
        if (out_valid !== 1'b1) begin
          failures++;
          $display("FAIL stream_valid c=%0d got=%b exp=1", c, out_valid);
        end else nvalid++;
        checks++;
        if (got_k() !== exp[c-3].k) begin
          failures++;
          $display("FAIL stream_keys beat=%0d got=%h exp=%h", c-3, got_k(), exp[c-3].k);
        end
`ifdef OEM_SORT_IDX_EN
        checks++;
        if (got_i() !== exp[c-3].ix) begin
          failures++;
          $display("FAIL stream_idx beat=%0d got=%h exp=%h", c-3, got_i(), exp[c-3].ix);
        end
`endif
      end
      if (c < 8) begin
        k = rand_keys();
        exp[c] = model(k, c[0]);
        drive(k, c[0], 1'b1);
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL stream_in_ready c=%0d got=%b exp=1", c, in_ready);
        end
      end else begin
        drive('0, 1'b0, 1'b0);
      end
      step();
    end
    checks++;
    if (nvalid != 8) begin
      failures++;
      $display("FAIL stream_count got=%0d exp=8", nvalid);
    end
  endtask

  task automatic test_backpressure();
    beat_t exp [4];
    keys_t bk [4];
    keys_t snap;
    int nb = 0;
    int nr = 0;
    int hold = 0;
    bit started = 0;
    bit fire_in;
    for (int i = 0; i < 4; i++) begin
      bk[i] = rand_keys();
      exp[i] = model(bk[i], i[0]);
    end
    out_ready = 1'b1;
    for (int s = 0; s < 40 && !(nb == 4 && nr == 4); s++) begin
      if (!started && out_valid) begin
        started = 1;
        hold = 5;
        snap = got_k();
      end
      if (hold > 0) begin
        out_ready = 1'b0;
        hold--;
      end else begin
        out_ready = 1'b1;
      end
      if (nb < 4) drive(bk[nb], nb[0], 1'b1);
      else drive('0, 1'b0, 1'b0);
      #1;
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || got_k() !== snap) begin
          failures++;
          $display("FAIL bp_hold in_ready=%b out_valid=%b keys=%h exp_keys=%h",
                   in_ready, out_valid, got_k(), snap);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (nr >= 4 || got_k() !== exp[nr].k) begin
          failures++;
          $display("FAIL bp_keys n=%0d got=%h exp=%h", nr, got_k(), exp[nr & 3].k);
        end
`ifdef OEM_SORT_IDX_EN
        checks++;
        if (nr >= 4 || got_i() !== exp[nr].ix) begin
          failures++;
          $display("FAIL bp_idx n=%0d got=%h exp=%h", nr, got_i(), exp[nr & 3].ix);
        end
`endif
        nr++;
      end
      fire_in = in_valid && in_ready;
      step();
      if (fire_in) nb++;
    end
    checks++;
    if (nr != 4 || nb != 4) begin
      failures++;
      $display("FAIL bp_delivered got=%0d sent=%0d exp=4", nr, nb);
    end
  endtask

  task automatic test_reset_midflight();
    int leaks = 0;
    out_ready = 1'b1;
    drive(rand_keys(), 1'b0, 1'b1);
    step();
    drive(rand_keys(), 1'b1, 1'b1);
    step();
    rst = 1'b1;
    drive(rand_keys(), 1'b0, 1'b1);
    step();
    rst = 1'b0;
    drive('0, 1'b0, 1'b0);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_ctrl out_valid=%b busy=%b in_ready=%b exp=0,0,1",
               out_valid, busy, in_ready);
    end
    checks++;
    if (got_k() !== keys_t'(0)) begin
      failures++;
      $display("FAIL midrst_keys got=%h exp=0", got_k());
    end
`ifdef OEM_SORT_IDX_EN
    checks++;
    if (got_i() !== idxs_t'(0)) begin
      failures++;
      $display("FAIL midrst_idx got=%h exp=0", got_i());
    end
`endif
    for (int s = 0; s < 6; s++) begin
      step();
      if (out_valid) leaks++;
    end
    checks++;
    if (leaks != 0) begin
      failures++;
      $display("FAIL midrst_leak got=%0d exp=0", leaks);
    end
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive('0, 1'b0, 1'b0);
    test_reset();
    test_directed();
    drain();
    test_stream();
    drain();
    test_backpressure();
    drain();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
